// File: rtl/pll_dyn_ctrl.sv
// Runtime sequencer for a Gowin rPLL with dynamic IDSEL/FBDSEL/ODSEL: reset pulse, lock wait with
// timeout/retry, lock qualification and automatic re-lock. Optional loss counter: PLL_DYN_CTRL_LOSS_CNT_EN.
module pll_dyn_ctrl #(
    parameter int         RST_CYCLES   = 16,
    parameter int         LOCK_TIMEOUT = 65535,
    parameter int         LOCK_STABLE  = 1024,
    parameter int         MAX_RETRY    = 3,
    parameter logic [5:0] DEF_IDSEL    = 6'd0,
    parameter logic [5:0] DEF_FBDSEL   = 6'd0,
    parameter logic [5:0] DEF_ODSEL    = 6'd0
) (
    input  logic       clkin,
    input  logic       resetn,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [5:0] req_idsel,
    input  logic [5:0] req_fbdsel,
    input  logic [5:0] req_odsel,
    output logic       pll_reset,
    output logic [5:0] pll_idsel,
    output logic [5:0] pll_fbdsel,
    output logic [5:0] pll_odsel,
    input  logic       pll_lock,
    output logic       locked,
    output logic       busy,
    output logic       err,
    output logic [3:0] retry_cnt,
    output logic       lost_lock,
    output logic [7:0] loss_cnt
);

    localparam int RST_W = $clog2(RST_CYCLES + 1);
    localparam int TMR_W = $clog2(LOCK_TIMEOUT + 1);
    localparam int STB_W = $clog2(LOCK_STABLE + 1);

    localparam logic [RST_W-1:0] RST_LAST = RST_W'(RST_CYCLES - 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(LOCK_TIMEOUT - 1);
    localparam logic [STB_W-1:0] STB_LAST = STB_W'(LOCK_STABLE - 1);
    localparam logic [3:0]       RETRY_MAX = 4'(MAX_RETRY);

    typedef enum logic [2:0] {
        S_RESET_PLL,
        S_WAIT_LOCK,
        S_STABLE,
        S_RUN,
        S_FAIL
    } state_t;

    state_t            state_q, state_d;
    logic [RST_W-1:0]  rst_cnt_q, rst_cnt_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic [STB_W-1:0]  stable_cnt_q, stable_cnt_d;
    logic [3:0]        retry_cnt_q, retry_cnt_d;
    logic [5:0]        idsel_q, idsel_d;
    logic [5:0]        fbdsel_q, fbdsel_d;
    logic [5:0]        odsel_q, odsel_d;
    logic              err_q, err_d;
    logic              pll_reset_q, pll_reset_d;
    logic              locked_q, locked_d;
    logic              busy_q, busy_d;
    logic              req_ready_q, req_ready_d;
    logic              lost_lock_q, lost_lock_d;
    logic              lock_meta_q, lock_s_q;
    logic              accept;

    // pll_lock comes from the PLL output domain; two flops before any decision uses it.
    always_ff @(posedge clkin or negedge resetn) begin
        if (!resetn) begin
            lock_meta_q <= 1'b0;
            lock_s_q    <= 1'b0;
        end else begin
            lock_meta_q <= pll_lock;
            lock_s_q    <= lock_meta_q;
        end
    end

    always_comb begin
        state_d      = state_q;
        rst_cnt_d    = rst_cnt_q;
        timer_d      = timer_q;
        stable_cnt_d = stable_cnt_q;
        retry_cnt_d  = retry_cnt_q;
        idsel_d      = idsel_q;
        fbdsel_d     = fbdsel_q;
        odsel_d      = odsel_q;
        err_d        = err_q;
        lost_lock_d  = 1'b0;
        accept       = 1'b0;

        case (state_q)
            S_RESET_PLL: begin
                if (rst_cnt_q == RST_LAST) begin
                    state_d = S_WAIT_LOCK;
                    timer_d = '0;
                end else begin
                    rst_cnt_d = rst_cnt_q + RST_W'(1);
                end
            end
            S_WAIT_LOCK: begin
                // Lock is checked first so it wins over a coincident timeout.
                if (lock_s_q) begin
                    state_d      = S_STABLE;
                    stable_cnt_d = '0;
                end else if (timer_q == TMR_LAST) begin
                    if (retry_cnt_q < RETRY_MAX) begin
                        retry_cnt_d = retry_cnt_q + 4'd1;
                        state_d     = S_RESET_PLL;
                        rst_cnt_d   = '0;
                    end else begin
                        state_d = S_FAIL;
                        err_d   = 1'b1;
                    end
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            S_STABLE: begin
                if (!lock_s_q) begin
                    state_d = S_WAIT_LOCK;
                    timer_d = '0;
                end else if (stable_cnt_q == STB_LAST) begin
                    state_d = S_RUN;
                end else begin
                    stable_cnt_d = stable_cnt_q + STB_W'(1);
                end
            end
            S_RUN: begin
                // RUN is only entered with lock_s high, so a low level here is the falling edge.
                if (!lock_s_q) begin
                    lost_lock_d = 1'b1;
                    retry_cnt_d = '0;
                    state_d     = S_RESET_PLL;
                    rst_cnt_d   = '0;
                end
                accept = req_valid;
            end
            S_FAIL: begin
                accept = req_valid;
            end
            default: begin
                state_d   = S_RESET_PLL;
                rst_cnt_d = '0;
            end
        endcase

        if (accept) begin
            idsel_d     = req_idsel;
            fbdsel_d    = req_fbdsel;
            odsel_d     = req_odsel;
            err_d       = 1'b0;
            retry_cnt_d = '0;
            state_d     = S_RESET_PLL;
            rst_cnt_d   = '0;
        end

        // Status outputs are decoded from the next state so they register alongside it.
        pll_reset_d = (state_d == S_RESET_PLL) || (state_d == S_FAIL);
        locked_d    = (state_d == S_RUN);
        busy_d      = (state_d == S_RESET_PLL) || (state_d == S_WAIT_LOCK) || (state_d == S_STABLE);
        req_ready_d = (state_d == S_RUN) || (state_d == S_FAIL);
    end

    always_ff @(posedge clkin or negedge resetn) begin
        if (!resetn) begin
            state_q      <= S_RESET_PLL;
            rst_cnt_q    <= '0;
            timer_q      <= '0;
            stable_cnt_q <= '0;
            retry_cnt_q  <= '0;
            idsel_q      <= DEF_IDSEL;
            fbdsel_q     <= DEF_FBDSEL;
            odsel_q      <= DEF_ODSEL;
            err_q        <= 1'b0;
            pll_reset_q  <= 1'b1;
            locked_q     <= 1'b0;
            busy_q       <= 1'b1;
            req_ready_q  <= 1'b0;
            lost_lock_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            rst_cnt_q    <= rst_cnt_d;
            timer_q      <= timer_d;
            stable_cnt_q <= stable_cnt_d;
            retry_cnt_q  <= retry_cnt_d;
            idsel_q      <= idsel_d;
            fbdsel_q     <= fbdsel_d;
            odsel_q      <= odsel_d;
            err_q        <= err_d;
            pll_reset_q  <= pll_reset_d;
            locked_q     <= locked_d;
            busy_q       <= busy_d;
            req_ready_q  <= req_ready_d;
            lost_lock_q  <= lost_lock_d;
        end
    end

`ifdef PLL_DYN_CTRL_LOSS_CNT_EN
    logic [7:0] loss_cnt_q, loss_cnt_d;

    always_comb begin
        loss_cnt_d = loss_cnt_q;
        if (lost_lock_d && (loss_cnt_q != 8'hFF)) begin
            loss_cnt_d = loss_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clkin or negedge resetn) begin
        if (!resetn) begin
            loss_cnt_q <= 8'd0;
        end else begin
            loss_cnt_q <= loss_cnt_d;
        end
    end

    assign loss_cnt = loss_cnt_q;
`else
    assign loss_cnt = 8'd0;
`endif

    assign req_ready  = req_ready_q;
    assign pll_reset  = pll_reset_q;
    assign pll_idsel  = idsel_q;
    assign pll_fbdsel = fbdsel_q;
    assign pll_odsel  = odsel_q;
    assign locked     = locked_q;
    assign busy       = busy_q;
    assign err        = err_q;
    assign retry_cnt  = retry_cnt_q;
    assign lost_lock  = lost_lock_q;

endmodule

// File: tb/tb_pll_dyn_ctrl.sv
// Scoreboard bench for pll_dyn_ctrl: stimulus queues every expected output change with its cycle,
// a negedge monitor pops one entry per observed change and compares the full output vector.
module tb_pll_dyn_ctrl;

    typedef struct packed {
        logic       pr;
        logic [5:0] id;
        logic [5:0] fb;
        logic [5:0] od;
        logic       locked;
        logic       busy;
        logic       err;
        logic       rdy;
        logic [3:0] rc;
        logic       ll;
        logic [7:0] lc;
    } snap_t;

    typedef struct {
        int    cyc;
        snap_t s;
    } exp_t;

    logic       clk = 1'b0;
    logic       resetn;
    logic       req_valid;
    logic       req_ready;
    logic [5:0] req_idsel, req_fbdsel, req_odsel;
    logic       pll_reset;
    logic [5:0] pll_idsel, pll_fbdsel, pll_odsel;
    logic       pll_lock;
    logic       locked, busy, err, lost_lock;
    logic [3:0] retry_cnt;
    logic [7:0] loss_cnt;

    int    cyc = 0;
    int    checks = 0;
    int    errors = 0;
    exp_t  exp_q[$];
    snap_t m;
    snap_t prev;
    bit    first = 1'b1;

    pll_dyn_ctrl #(
        .RST_CYCLES  (4),
        .LOCK_TIMEOUT(32),
        .LOCK_STABLE (8),
        .MAX_RETRY   (2),
        .DEF_IDSEL   (6'h3F),
        .DEF_FBDSEL  (6'h0B),
        .DEF_ODSEL   (6'h38)
    ) dut (
        .clkin     (clk),
        .resetn    (resetn),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_idsel (req_idsel),
        .req_fbdsel(req_fbdsel),
        .req_odsel (req_odsel),
        .pll_reset (pll_reset),
        .pll_idsel (pll_idsel),
        .pll_fbdsel(pll_fbdsel),
        .pll_odsel (pll_odsel),
        .pll_lock  (pll_lock),
        .locked    (locked),
        .busy      (busy),
        .err       (err),
        .retry_cnt (retry_cnt),
        .lost_lock (lost_lock),
        .loss_cnt  (loss_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic snap_t cur_snap();
        snap_t s;
        s.pr     = pll_reset;
        s.id     = pll_idsel;
        s.fb     = pll_fbdsel;
        s.od     = pll_odsel;
        s.locked = locked;
        s.busy   = busy;
        s.err    = err;
        s.rdy    = req_ready;
        s.rc     = retry_cnt;
        s.ll     = lost_lock;
        s.lc     = loss_cnt;
        return s;
    endfunction

    // Monitor: any change of the output vector is one transaction.
    always @(negedge clk) begin
        snap_t s;
        exp_t  e;
        s = cur_snap();
        if (first || (s !== prev)) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_change cyc=%0d got=%h (nothing expected)", cyc, s);
            end else begin
                e = exp_q.pop_front();
                if ((e.cyc != cyc) || (e.s !== s)) begin
                    errors++;
                    $display("FAIL event cyc=%0d got=%h, required cyc=%0d vec=%h", cyc, s, e.cyc, e.s);
                end else begin
                    $display("ok   event cyc=%0d vec=%h", cyc, s);
                end
            end
        end
        first = 1'b0;
        prev  = s;
    end

    task automatic ev(input int c);
        exp_t e;
        e.cyc = c;
        e.s   = m;
        exp_q.push_back(e);
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic m_boot();
        m = '0;
        m.pr = 1'b1; m.busy = 1'b1;
        m.id = 6'h3F; m.fb = 6'h0B; m.od = 6'h38;
    endtask
    task automatic m_rst();  m.pr = 1'b1; m.locked = 1'b0; m.busy = 1'b1; m.rdy = 1'b0; endtask
    task automatic m_wait(); m.pr = 1'b0; m.locked = 1'b0; m.busy = 1'b1; m.rdy = 1'b0; endtask
    task automatic m_run();  m.pr = 1'b0; m.locked = 1'b1; m.busy = 1'b0; m.rdy = 1'b1; endtask
    task automatic m_fail(); m.pr = 1'b1; m.locked = 1'b0; m.busy = 1'b0; m.rdy = 1'b1; m.err = 1'b1; endtask
    task automatic m_loss();
        m.ll = 1'b1;
`ifdef PLL_DYN_CTRL_LOSS_CNT_EN
        if (m.lc != 8'hFF) m.lc = m.lc + 8'd1;
`endif
    endtask
    task automatic m_req(input logic [5:0] i, input logic [5:0] f, input logic [5:0] o);
        m_rst();
        m.id = i; m.fb = f; m.od = o; m.err = 1'b0; m.rc = 4'd0;
    endtask

    // Latency convention: a pll_lock change driven at the negedge of cycle c is sampled at posedge c+1,
    // reaches lock_s at c+2 and is acted on at c+3. A re-lock from reset entry A lands in RUN at A+13.
    initial begin
        int c;
        snap_t s;
        resetn = 1'b0; pll_lock = 1'b0; req_valid = 1'b0;
        req_idsel = '0; req_fbdsel = '0; req_odsel = '0;
        m_boot();
        ev(1);

        // 1. Boot
        wait_cyc(3);
        resetn = 1'b1;
        c = cyc;
        m_wait(); ev(c + 4);
        wait_cyc(c + 10);
        pll_lock = 1'b1;
        c = cyc;
        m_run(); ev(c + 11);

        // 2. Request in RUN
        wait_cyc(c + 13);
        c = cyc;
        req_valid = 1'b1; req_idsel = 6'h3E; req_fbdsel = 6'h0A; req_odsel = 6'h37;
        m_req(6'h3E, 6'h0A, 6'h37); ev(c + 1);
        m_wait(); ev(c + 5);
        m_run();  ev(c + 14);
        wait_cyc(c + 1);
        req_valid = 1'b0;

        // 3. Timeout with retries, then FAIL
        wait_cyc(c + 16);
        c = cyc;
        req_valid = 1'b1; req_idsel = 6'h2A; req_fbdsel = 6'h15; req_odsel = 6'h07;
        pll_lock = 1'b0;
        m_req(6'h2A, 6'h15, 6'h07); ev(c + 1);
        m_wait(); ev(c + 5);
        m_rst(); m.rc = 4'd1; ev(c + 37);
        m_wait(); ev(c + 41);
        m_rst(); m.rc = 4'd2; ev(c + 73);
        m_wait(); ev(c + 77);
        m_fail(); ev(c + 109);
        wait_cyc(c + 1);
        req_valid = 1'b0;

        // 3b/4. Request out of FAIL clears err; lock glitch at stable count 5 restarts qualification
        wait_cyc(c + 112);
        c = cyc;
        req_valid = 1'b1; req_idsel = 6'h11; req_fbdsel = 6'h22; req_odsel = 6'h33;
        pll_lock = 1'b1;
        m_req(6'h11, 6'h22, 6'h33); ev(c + 1);
        m_wait(); ev(c + 5);
        m_run();  ev(c + 21);
        wait_cyc(c + 1);
        req_valid = 1'b0;
        wait_cyc(c + 9);
        pll_lock = 1'b0;
        wait_cyc(c + 10);
        pll_lock = 1'b1;

        // 5. Lock loss in RUN, repeated 300 times in total
        wait_cyc(c + 23);
        for (int n = 0; n < 300; n++) begin
            c = cyc;
            pll_lock = 1'b0;
            m_rst(); m.rc = 4'd0; m_loss(); ev(c + 3);
            m.ll = 1'b0; ev(c + 4);
            m_wait(); ev(c + 7);
            m_run();  ev(c + 16);
            wait_cyc(c + 4);
            pll_lock = 1'b1;
            wait_cyc(c + 17);
        end

        // 5b. Lock loss coincident with an accepted request; lock stays down into a retry
        c = cyc;
        pll_lock = 1'b0;
        wait_cyc(c + 2);
        req_valid = 1'b1; req_idsel = 6'h05; req_fbdsel = 6'h1A; req_odsel = 6'h2C;
        m_req(6'h05, 6'h1A, 6'h2C); m_loss(); ev(c + 3);
        m.ll = 1'b0; ev(c + 4);
        m_wait(); ev(c + 7);
        m_rst(); m.rc = 4'd1; ev(c + 39);
        m_wait(); ev(c + 43);
        wait_cyc(c + 3);
        req_valid = 1'b0;

        // 6. Asynchronous reset mid-WAIT_LOCK with retry_cnt=1
        wait_cyc(c + 50);
        #2;
        resetn = 1'b0;
        #1;
        m_boot();
        s = cur_snap();
        checks++;
        if (s !== m) begin
            errors++;
            $display("FAIL async_reset got=%h required=%h", s, m);
        end else begin
            $display("ok   async_reset vec=%h", s);
        end
        ev(c + 51);

        wait_cyc(c + 55);
        while (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            checks++;
            errors++;
            $display("FAIL missing_event required cyc=%0d vec=%h, got nothing", e.cyc, e.s);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
